// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS-subset control path.
// Holds the state encodings, the opcode constants and the alu_op / alu_src_b / pc_source
// encodings. The control FSM, the datapath and the ALU-control block all import it.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN adds the S_HALT encoding.
package mc_ctrl_pkg;

   localparam int unsigned STATE_W  = 4;
   localparam int unsigned OPCODE_W = 6;

   // Control FSM states
   typedef enum logic [STATE_W-1:0] {
      S_RST   = 4'd0,
      S_IF    = 4'd1,
      S_ID    = 4'd2,
      S_MADDR = 4'd3,
      S_MRD   = 4'd4,
      S_MWB   = 4'd5,
      S_MWR   = 4'd6,
      S_EXR   = 4'd7,
      S_WBR   = 4'd8,
      S_BEQ   = 4'd9,
      S_J     = 4'd10,
      S_EXI   = 4'd11,
      S_WBI   = 4'd12
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ,
      S_HALT  = 4'd13
`endif
   } state_e;

   // Decoded opcodes (IR[31:26])
   localparam logic [OPCODE_W-1:0] OP_R    = 6'b000000;
   localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
   localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;
   localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OPCODE_W-1:0] OP_J    = 6'b000010;
   localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;

   // ALU operation class
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // ALU B operand select
   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS-subset control unit (Moore FSM with memory-ready handshake).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   opcode[5:0]         IR[31:26], sampled in S_ID and S_MADDR only
//   mem_ready           memory completes the current read/write this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
//   pc_source[1:0], alu_op[1:0], alu_src_a, alu_src_b[1:0], reg_write, reg_dst
//                       datapath strobes, decoded from the state register
//   state[STATE_W-1:0]  current state, for debug
//   err                 illegal-opcode halt flag (only with MC_CTRL_ILLEGAL_TRAP_EN)
// Strobes decode directly from the state register, so an asynchronous reset clears them
// in the same cycle. The only Mealy terms are ir_write/pc_write in S_IF, qualified by
// mem_ready so a stalled fetch loads IR and PC exactly once.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (undecoded opcode halts in S_HALT).
module mc_ctrl_fsm #(
   parameter int unsigned STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mem_to_reg,
   output logic [1:0]         pc_source,
   output logic [1:0]         alu_op,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               reg_write,
   output logic               reg_dst,
   output logic [STATE_W-1:0] state
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   ,
   output logic               err
`endif
);
   import mc_ctrl_pkg::*;

   state_e cur;
   state_e nxt;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur <= S_RST;
      else     cur <= nxt;
   end

   // Next-state logic
   always_comb begin
      nxt = cur;
      case (cur)
         S_RST:   nxt = S_IF;
         S_IF:    nxt = mem_ready ? S_ID : S_IF;
         S_ID: begin
            case (opcode)
               OP_LW, OP_SW: nxt = S_MADDR;
               OP_R:         nxt = S_EXR;
               OP_BEQ:       nxt = S_BEQ;
               OP_J:         nxt = S_J;
               OP_ADDI:      nxt = S_EXI;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               default:      nxt = S_HALT;
`else
               default:      nxt = S_IF;
`endif
            endcase
         end
         // Opcode is re-sampled here; anything but LW/SW falls back to fetch.
         S_MADDR: begin
            if (opcode == OP_LW)      nxt = S_MRD;
            else if (opcode == OP_SW) nxt = S_MWR;
            else                      nxt = S_IF;
         end
         S_MRD:   nxt = mem_ready ? S_MWB : S_MRD;
         S_MWB:   nxt = S_IF;
         S_MWR:   nxt = mem_ready ? S_IF : S_MWR;
         S_EXR:   nxt = S_WBR;
         S_WBR:   nxt = S_IF;
         S_BEQ:   nxt = S_IF;
         S_J:     nxt = S_IF;
         S_EXI:   nxt = S_WBI;
         S_WBI:   nxt = S_IF;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         S_HALT:  nxt = S_HALT;
`endif
         default: nxt = S_RST;
      endcase
   end

   // Output decode: every strobe defaults to 0
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      pc_source     = PCSRC_ALU;
      alu_op        = ALU_ADD;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      case (cur)
         S_IF: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_ID: begin
            alu_src_b = SRCB_IMM_SH2;
         end
         S_MADDR, S_EXI: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_EXR: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
         end
         S_WBR: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BEQ: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
         S_J: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         S_WBI: begin
            reg_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign state = STATE_W'(cur);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   assign err = (cur == S_HALT);
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized self-checking bench for mc_ctrl_fsm.
// For each instruction the bench expands the opcode and randomly chosen stall counts into
// the expected per-cycle trace (state, strobes, mem_ready to drive), then replays it.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (halt checks).
module tb_mc_ctrl_fsm;
   import mc_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, alu_src_a, reg_write, reg_dst;
   logic [1:0] pc_source, alu_op, alu_src_b;
   logic [3:0] state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic       err;
`endif

   mc_ctrl_fsm #(.STATE_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .pc_source(pc_source), .alu_op(alu_op),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
      .reg_dst(reg_dst), .state(state)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      , .err(err)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Strobe bundle, in port order
   logic [16:0] obs;
   assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst};

   function automatic logic [16:0] ov(input logic pcw, input logic pcwc, input logic iord,
                                      input logic mrd, input logic mwr, input logic irw,
                                      input logic m2r, input logic [1:0] pcs,
                                      input logic [1:0] aop, input logic asa,
                                      input logic [1:0] asb, input logic rw, input logic rd);
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, pcs, aop, asa, asb, rw, rd};
   endfunction

   typedef struct packed {
      logic       mr;
      logic [5:0] opc;
      logic [3:0] st;
      logic [16:0] outs;
   } rec_t;

   rec_t q[$];

   function automatic logic [5:0] r6();
      return 6'($urandom);
   endfunction

   // mem_ready in cycles where it must not matter
   function automatic logic fr(input bit tie);
      return tie ? 1'b1 : 1'($urandom);
   endfunction

   function automatic bit legal(input logic [5:0] op);
      return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
   endfunction

   task automatic push(input logic mr, input logic [5:0] opc, input state_e st,
                       input logic [16:0] outs);
      rec_t r;
      r.mr = mr; r.opc = opc; r.st = 4'(st); r.outs = outs;
      q.push_back(r);
   endtask

   // Expand one instruction into its expected cycle trace
   task automatic build(input logic [5:0] op, input int fst, input int mst, input bit tie);
      logic [16:0] mem_o;
      for (int i = 0; i < fst; i++)
         push(1'b0, r6(), S_IF, ov(0,0,0,1,0,0,0,2'b00,2'b00,0,2'b01,0,0));
      push(1'b1, r6(), S_IF, ov(1,0,0,1,0,1,0,2'b00,2'b00,0,2'b01,0,0));
      push(fr(tie), op, S_ID, ov(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b11,0,0));
      case (op)
         6'b100011, 6'b101011: begin
            push(fr(tie), op, S_MADDR, ov(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0));
            if (op == 6'b100011) begin
               mem_o = ov(0,0,1,1,0,0,0,2'b00,2'b00,0,2'b00,0,0);
               for (int i = 0; i < mst; i++) push(1'b0, r6(), S_MRD, mem_o);
               push(1'b1, r6(), S_MRD, mem_o);
               push(fr(tie), r6(), S_MWB, ov(0,0,0,0,0,0,1,2'b00,2'b00,0,2'b00,1,0));
            end else begin
               mem_o = ov(0,0,1,0,1,0,0,2'b00,2'b00,0,2'b00,0,0);
               for (int i = 0; i < mst; i++) push(1'b0, r6(), S_MWR, mem_o);
               push(1'b1, r6(), S_MWR, mem_o);
            end
         end
         6'b000000: begin
            push(fr(tie), r6(), S_EXR, ov(0,0,0,0,0,0,0,2'b00,2'b10,1,2'b00,0,0));
            push(fr(tie), r6(), S_WBR, ov(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,1,1));
         end
         6'b001000: begin
            push(fr(tie), r6(), S_EXI, ov(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0));
            push(fr(tie), r6(), S_WBI, ov(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,1,0));
         end
         6'b000100: push(fr(tie), r6(), S_BEQ, ov(0,1,0,0,0,0,0,2'b01,2'b01,1,2'b00,0,0));
         6'b000010: push(fr(tie), r6(), S_J,   ov(1,0,0,0,0,0,0,2'b10,2'b00,0,2'b00,0,0));
         default: ;
      endcase
   endtask

   // Replay the queued trace; optionally pulse rst inside the cycle whose state is stop_st
   task automatic run(input int stop_st);
      rec_t r;
      while (q.size() > 0) begin
         r = q.pop_front();
         @(negedge clk);
         mem_ready = r.mr;
         opcode    = r.opc;
         #1;
         check($sformatf("outs_st%0d", r.st), 32'(obs), 32'(r.outs));
         check("state", 32'(state), 32'(r.st));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         check("err_low", 32'(err), 32'd0);
`endif
         if (stop_st >= 0 && int'(r.st) == stop_st) begin
            q.delete();
            reset_now();
         end
      end
   endtask

   task automatic reset_now();
      rst = 1'b1;
      #1;
      check("rst_outs", 32'(obs), 32'd0);
      check("rst_state", 32'(state), 32'(S_RST));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      check("rst_err", 32'(err), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_hold_outs", 32'(obs), 32'd0);
      check("rst_hold_state", 32'(state), 32'(S_RST));
   endtask

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   task automatic halt_check();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_ready = 1'($urandom);
         opcode    = r6();
         #1;
         check("halt_outs", 32'(obs), 32'd0);
         check("halt_state", 32'(state), 32'(S_HALT));
         check("halt_err", 32'(err), 32'd1);
      end
      reset_now();
   endtask
`endif

   task automatic do_instr(input logic [5:0] op, input int fst, input int mst, input bit tie);
      build(op, fst, mst, tie);
      run(-1);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      if (!legal(op)) halt_check();
`endif
   endtask

   logic [5:0] ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

   initial begin
      logic [5:0] op;
      rst       = 1'b0;
      mem_ready = 1'b1;
      opcode    = 6'd0;
      #2;
      reset_now();

      // Directed cases
      do_instr(6'b100011, 0, 0, 1'b1);   // LW, mem_ready tied high: 5 cycles
      do_instr(6'b101011, 0, 3, 1'b0);   // SW, 3-cycle write stall
      do_instr(6'b000000, 2, 0, 1'b0);   // R, 2-cycle fetch stall
      do_instr(6'b000100, 0, 0, 1'b1);   // BEQ
      do_instr(6'b000010, 0, 0, 1'b1);   // J
      do_instr(6'b001000, 1, 0, 1'b0);   // ADDI
      do_instr(6'b111111, 0, 0, 1'b0);   // undecoded opcode

      // Randomized instruction stream
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            op = r6();
            while (legal(op)) op = r6();
         end else begin
            op = ops[$urandom_range(0, 5)];
         end
         do_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
      end

      // Reset while LW is stalled in its data read
      build(6'b100011, 0, 2, 1'b0);
      run(int'(S_MRD));
      do_instr(6'b000010, 0, 0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
